// File: rtl/debounce_pkg.sv
// Shared types and constants for the key debouncer.
package debounce_pkg;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_QUALIFY = 1'b1
  } state_t;

  localparam int unsigned DEBOUNCE_CYCLES_MIN = 2;

  // Qualification counter width; needs to hold 0..cycles-1 and is never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles > DEBOUNCE_CYCLES_MIN) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1 <= RST_VAL;
      q  <= RST_VAL;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Debounces a raw asynchronous input into a clean level with single-cycle edge pulses.
module key_debounce
  import debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter logic        IDLE_LEVEL      = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic data,
  output logic rise_p,
  output logic fall_p,
  output logic busy
);

  localparam int unsigned    CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             key_s;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  sync_2ff #(
    .RST_VAL (IDLE_LEVEL)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (key_in),
    .q   (key_s)
  );

  // A candidate level must survive the detect edge plus DEBOUNCE_CYCLES qualify edges.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= ST_STABLE;
      cnt    <= '0;
      data   <= IDLE_LEVEL;
      rise_p <= 1'b0;
      fall_p <= 1'b0;
      busy   <= 1'b0;
    end else begin
      rise_p <= 1'b0;
      fall_p <= 1'b0;
      case (state)
        ST_STABLE: begin
          cnt <= '0;
          if (key_s != data) begin
            state <= ST_QUALIFY;
            busy  <= 1'b1;
          end
        end
        ST_QUALIFY: begin
          if (key_s == data) begin
            state <= ST_STABLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            data   <= key_s;
            rise_p <= key_s;
            fall_p <= ~key_s;
            state  <= ST_STABLE;
            busy   <= 1'b0;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= ST_STABLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed self-checking bench for key_debounce at DEBOUNCE_CYCLES = 16, 2 and 1000.
module tb_key_debounce;

  logic clk;
  logic rst;
  logic key_in;
  logic data, rise_p, fall_p, busy;
  logic data2, rise2, fall2, busy2;
  logic data1k, rise1k, fall1k, busy1k;

  int errors   = 0;
  int checks   = 0;
  int rise_cnt = 0;
  int fall_cnt = 0;

  key_debounce u_dut (
    .clk (clk), .rst (rst), .key_in (key_in),
    .data (data), .rise_p (rise_p), .fall_p (fall_p), .busy (busy)
  );

  key_debounce #(.DEBOUNCE_CYCLES(2)) u_dut2 (
    .clk (clk), .rst (rst), .key_in (key_in),
    .data (data2), .rise_p (rise2), .fall_p (fall2), .busy (busy2)
  );

  key_debounce #(.DEBOUNCE_CYCLES(1000)) u_dut1k (
    .clk (clk), .rst (rst), .key_in (key_in),
    .data (data1k), .rise_p (rise1k), .fall_p (fall1k), .busy (busy1k)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: sample 1 time unit after the edge, enforce pulse exclusivity, tally DUT16 pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("excl16", rise_p & fall_p, 1'b0);
    chk("excl2", rise2 & fall2, 1'b0);
    chk("excl1k", rise1k & fall1k, 1'b0);
    if (rise_p) rise_cnt++;
    if (fall_p) fall_cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // Reset held with key_in at the non-idle level
    rst    = 1'b0;
    key_in = 1'b1;
    run(3);
    chk("rst_data", data, 1'b0);
    chk("rst_rise", rise_p, 1'b0);
    chk("rst_fall", fall_p, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_data2", data2, 1'b0);
    chk("rst_data1k", data1k, 1'b0);

    // Release: qualification runs, rise at edge 19
    rst = 1'b1;
    rise_cnt = 0; fall_cnt = 0;
    run(2);
    chk("rel_busy_e2", busy, 1'b0);
    tick();
    chk("rel_busy_e3", busy, 1'b1);
    run(15);
    chk("rel_data_e18", data, 1'b0);
    chk("rel_busy_e18", busy, 1'b1);
    tick();
    chk("rel_data_e19", data, 1'b1);
    chk("rel_rise_e19", rise_p, 1'b1);
    chk("rel_busy_e19", busy, 1'b0);
    tick();
    chk("rel_rise_e20", rise_p, 1'b0);
    chk("rel_data_e20", data, 1'b1);
    chk_int("rel_rise_cnt", rise_cnt, 1);
    chk_int("rel_fall_cnt", fall_cnt, 0);

    // Clean 1->0 step
    key_in = 1'b0;
    rise_cnt = 0; fall_cnt = 0;
    run(18);
    chk("fall_data_e18", data, 1'b1);
    chk("fall_pulse_e18", fall_p, 1'b0);
    tick();
    chk("fall_data_e19", data, 1'b0);
    chk("fall_pulse_e19", fall_p, 1'b1);
    run(5);
    chk_int("fall_rise_cnt", rise_cnt, 0);
    chk_int("fall_fall_cnt", fall_cnt, 1);

    // Bounce 1,0,1,0 every 3 cycles, then settle high
    rise_cnt = 0; fall_cnt = 0;
    key_in = 1'b1; run(3);
    chk("bnc_busy_1", busy, 1'b1);
    key_in = 1'b0; run(3);
    chk("bnc_busy_2", busy, 1'b0);
    key_in = 1'b1; run(3);
    chk("bnc_busy_3", busy, 1'b1);
    key_in = 1'b0; run(3);
    chk("bnc_busy_4", busy, 1'b0);
    key_in = 1'b1;
    run(18);
    chk("bnc_data_e18", data, 1'b0);
    tick();
    chk("bnc_data_e19", data, 1'b1);
    chk("bnc_rise_e19", rise_p, 1'b1);
    run(5);
    chk_int("bnc_rise_cnt", rise_cnt, 1);
    chk_int("bnc_fall_cnt", fall_cnt, 0);

    // Back to low, then a 15-cycle glitch that must be rejected
    key_in = 1'b0;
    run(25);
    chk("gl_pre_data", data, 1'b0);
    rise_cnt = 0; fall_cnt = 0;
    key_in = 1'b1;
    run(15);
    chk("gl_busy_mid", busy, 1'b1);
    key_in = 1'b0;
    run(10);
    chk("gl_data", data, 1'b0);
    chk("gl_busy", busy, 1'b0);
    chk_int("gl_rise_cnt", rise_cnt, 0);
    chk_int("gl_fall_cnt", fall_cnt, 0);

    // Shortest accepted pulse: key_s seen high on edges 3..19
    rise_cnt = 0; fall_cnt = 0;
    key_in = 1'b1;
    run(17);
    key_in = 1'b0;
    tick();
    chk("p17_data_e18", data, 1'b0);
    tick();
    chk("p17_data_e19", data, 1'b1);
    chk("p17_rise_e19", rise_p, 1'b1);
    run(25);
    chk("p17_data_end", data, 1'b0);
    chk_int("p17_rise_cnt", rise_cnt, 1);
    chk_int("p17_fall_cnt", fall_cnt, 1);

    // Reset in the middle of qualification
    rise_cnt = 0; fall_cnt = 0;
    key_in = 1'b1;
    run(12);
    chk("mq_busy_pre", busy, 1'b1);
    rst = 1'b0;
    tick();
    chk("mq_data", data, 1'b0);
    chk("mq_busy", busy, 1'b0);
    chk("mq_rise", rise_p, 1'b0);
    rst = 1'b1;
    run(18);
    chk("mq_data_e18", data, 1'b0);
    tick();
    chk("mq_data_e19", data, 1'b1);
    chk("mq_rise_e19", rise_p, 1'b1);
    chk_int("mq_rise_cnt", rise_cnt, 1);
    chk_int("mq_fall_cnt", fall_cnt, 0);

    // Latency sweep: N+3 edges for N = 2, 16, 1000
    rst = 1'b0;
    key_in = 1'b0;
    run(2);
    chk("sw_rst_data", data, 1'b0);
    chk("sw_rst_data2", data2, 1'b0);
    chk("sw_rst_data1k", data1k, 1'b0);
    rst = 1'b1;
    key_in = 1'b1;
    run(4);
    chk("sw2_data_e4", data2, 1'b0);
    chk("sw2_busy_e4", busy2, 1'b1);
    tick();
    chk("sw2_data_e5", data2, 1'b1);
    chk("sw2_rise_e5", rise2, 1'b1);
    tick();
    chk("sw2_rise_e6", rise2, 1'b0);
    chk("sw2_data_e6", data2, 1'b1);
    run(12);
    chk("sw16_data_e18", data, 1'b0);
    tick();
    chk("sw16_rise_e19", rise_p, 1'b1);
    run(983);
    chk("sw1k_data_e1002", data1k, 1'b0);
    chk("sw1k_busy_e1002", busy1k, 1'b1);
    tick();
    chk("sw1k_data_e1003", data1k, 1'b1);
    chk("sw1k_rise_e1003", rise1k, 1'b1);
    tick();
    chk("sw1k_rise_e1004", rise1k, 1'b0);
    chk("sw1k_data_e1004", data1k, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
